// File: rtl/clk_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_buffer_pkg
//  Description : Shared constants and helpers for the elastic clock-aligned
//                pipeline buffer (clk_pipeline_buffer / clk_buffer_stage).
//  Contents    : CLK_BUFFER_MAX_DEPTH, CLK_BUFFER_DEFAULT_WIDTH,
//                clk_buffer_clog2() used to size the occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_buffer_pkg;

    localparam int CLK_BUFFER_MAX_DEPTH     = 16;
    localparam int CLK_BUFFER_DEFAULT_WIDTH = 8;

    // Ceiling log2; returns the bit width needed to hold values 0..value-1.
    function automatic int clk_buffer_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : clk_buffer_pkg
`default_nettype wire

// File: rtl/clk_buffer_stage.sv
`default_nettype none
// ============================================================================
//  Module      : clk_buffer_stage
//  Description : One handshaked register slice of the elastic pipeline.
//                Base build: a single data/valid register whose upstream
//                readiness (!valid | dn_ready) is formed by the parent.
//                With CLK_PIPELINE_BUFFER_SKID_EN defined: a main register
//                plus a skid entry, and a registered up_ready output.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                flush           - clears held valids, blocks all loads
//                up_data/up_valid (/up_ready in skid build) - input side
//                dn_data/dn_valid/dn_ready                 - output side
//  Macro       : CLK_PIPELINE_BUFFER_SKID_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_buffer_stage
    import clk_buffer_pkg::*;
#(
    parameter int WIDTH = CLK_BUFFER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
`ifdef CLK_PIPELINE_BUFFER_SKID_EN
    output logic             up_ready,
`endif
    output logic [WIDTH-1:0] dn_data,
    output logic             dn_valid,
    input  logic             dn_ready
);

`ifdef CLK_PIPELINE_BUFFER_SKID_EN

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             w_out_fire;
    logic             w_in_fire;

    // Readiness depends only on the skid flag, so it never sees dn_ready
    // combinationally.
    assign w_out_fire = r_main_valid & dn_ready & ~flush;
    assign w_in_fire  = up_valid & ~r_skid_valid & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // Upstream is blocked; refill main from the skid entry.
            if (w_out_fire) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_main_valid || w_out_fire) begin
                r_main_data  <= up_data;
                r_main_valid <= 1'b1;
            end else begin
                // Main is held this cycle: park the beat in the skid entry.
                r_skid_data  <= up_data;
                r_skid_valid <= 1'b1;
            end
        end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
        end
    end

    assign up_ready = ~r_skid_valid;
    assign dn_data  = r_main_data;
    assign dn_valid = r_main_valid;

`else

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_load;
    logic             w_advance;

    // An empty slot always accepts, which collapses bubbles.
    assign w_load    = up_valid & (~r_valid | dn_ready) & ~flush;
    assign w_advance = r_valid & dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= up_data;
            r_valid <= 1'b1;
        end else if (w_advance) begin
            r_valid <= 1'b0;
        end
    end

    assign dn_data  = r_data;
    assign dn_valid = r_valid;

`endif

endmodule : clk_buffer_stage
`default_nettype wire

// File: rtl/clk_pipeline_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : clk_pipeline_buffer
//  Description : Elastic valid/ready register pipeline of DEPTH stages with
//                occupancy reporting and synchronous flush.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                flush                        - discard every held beat
//                in_data/in_valid/in_ready    - upstream handshake
//                out_data/out_valid/out_ready - downstream handshake
//                count                        - beats currently held
//  Macro       : CLK_PIPELINE_BUFFER_SKID_EN - adds a skid entry per stage,
//                registers every ready, doubles capacity to 2*DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_pipeline_buffer
    import clk_buffer_pkg::*;
#(
    parameter  int WIDTH    = CLK_BUFFER_DEFAULT_WIDTH,
    parameter  int DEPTH    = 2,
`ifdef CLK_PIPELINE_BUFFER_SKID_EN
    localparam int CAPACITY = 2 * DEPTH,
`else
    localparam int CAPACITY = DEPTH,
`endif
    localparam int CW       = clk_buffer_clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    // Index k is the interface entering stage k; index DEPTH is the output.
    logic [WIDTH-1:0] w_dat [DEPTH+1];
    logic [DEPTH:0]   w_vld;
    logic [DEPTH:0]   w_rdy;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CW-1:0]    r_count;

    assign w_dat[0] = in_data;
    assign w_vld[0] = in_valid;

`ifdef CLK_PIPELINE_BUFFER_SKID_EN
    assign w_rdy[DEPTH] = out_ready;
`else
    // Ready ripples back from the output; formed here from the stage valids
    // so the chain is a single combinational block.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_vld[i+1] | w_rdy[i+1];
        end
    end
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        clk_buffer_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_data  (w_dat[i]),
            .up_valid (w_vld[i]),
`ifdef CLK_PIPELINE_BUFFER_SKID_EN
            .up_ready (w_rdy[i]),
`endif
            .dn_data  (w_dat[i+1]),
            .dn_valid (w_vld[i+1]),
            .dn_ready (w_rdy[i+1])
        );
    end

    // Flush blocks both handshakes for the cycle it is asserted.
    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = w_vld[DEPTH] & ~flush;
    assign out_data  = w_dat[DEPTH];

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_in_fire) - CW'(w_out_fire);
        end
    end

    assign count = r_count;

endmodule : clk_pipeline_buffer
`default_nettype wire

// File: tb/tb_clk_pipeline_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_pipeline_buffer
//  Description : Self-checking bench for clk_pipeline_buffer. Instance A is
//                8 bits x 3 stages (directed latency, backpressure, flush and
//                reset steps); instance B is 16 bits x 4 stages (random
//                valid, alternating ready). Negedge monitors keep a beat
//                queue and an occupancy model per instance.
//  Macro       : CLK_PIPELINE_BUFFER_SKID_EN - changes expected capacity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_pipeline_buffer;

`ifdef CLK_PIPELINE_BUFFER_SKID_EN
    localparam int A_CAP = 6;
    localparam int B_CAP = 8;
`else
    localparam int A_CAP = 3;
    localparam int B_CAP = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data, a_out_data;
    logic [$clog2(A_CAP+1)-1:0] a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data;
    logic [$clog2(B_CAP+1)-1:0] b_count;

    clk_pipeline_buffer #(.WIDTH(8), .DEPTH(3)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .count(a_count)
    );

    clk_pipeline_buffer #(.WIDTH(16), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .count(b_count)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboards / occupancy models ----------------
    logic [7:0]  a_q[$];
    logic [15:0] b_q[$];
    int a_model = 0;
    int b_model = 0;

    always @(negedge clk) begin
        if (rst || a_flush) begin
            a_q.delete();
            a_model = 0;
        end else begin
            check("a_count_model", 32'(a_count), a_model);
            if (a_out_valid && a_out_ready) begin
                check("a_sb_nonempty", 32'(a_q.size() != 0), 1);
                if (a_q.size() != 0) check("a_out_data_order", a_out_data, a_q.pop_front());
                a_model--;
            end
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(a_in_data);
                a_model++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst || b_flush) begin
            b_q.delete();
            b_model = 0;
        end else begin
            check("b_count_model", 32'(b_count), b_model);
            if (b_out_valid && b_out_ready) begin
                check("b_sb_nonempty", 32'(b_q.size() != 0), 1);
                if (b_q.size() != 0) check("b_out_data_order", b_out_data, b_q.pop_front());
                b_model--;
            end
            if (b_in_valid && b_in_ready) begin
                b_q.push_back(b_in_data);
                b_model++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int exp_acc;

        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_a_count", 32'(a_count), 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_count", 32'(b_count), 0);

        // Streaming: first beat shows after edge t+2 for depth 3
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h01;
        tick();
        check("lat_edge0_valid", a_out_valid, 0);
        a_in_data = 8'h02;
        tick();
        check("lat_edge1_valid", a_out_valid, 0);
        a_in_data = 8'h03;
        tick();
        check("lat_edge2_valid", a_out_valid, 1);
        check("lat_edge2_data", a_out_data, 8'h01);
        for (int v = 4; v <= 16; v++) begin
            a_in_data = 8'(v);
            tick();
        end
        check("stream_count", 32'(a_count), 3);
        check("stream_out_data", a_out_data, 8'h0E);
        a_in_valid = 1'b0;
        repeat (8) tick();
        check("stream_drained", 32'(a_count), 0);

        // Backpressure: 5 beats offered with out_ready low
        a_out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            a_in_valid = (acc < 5);
            a_in_data  = 8'h20 + 8'(acc);
            #1;
            if (a_in_valid && a_in_ready) acc++;
            tick();
        end
        a_in_valid = 1'b0;
        exp_acc = (A_CAP < 5) ? A_CAP : 5;
        #1;
        check("bp_accepts", acc, exp_acc);
        check("bp_count", 32'(a_count), exp_acc);
        check("bp_in_ready", a_in_ready, (exp_acc < A_CAP) ? 1 : 0);
        check("bp_out_data_head", a_out_data, 8'h20);
        a_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (acc == 5 && a_count == 0) break;
            a_in_valid = (acc < 5);
            a_in_data  = 8'h20 + 8'(acc);
            #1;
            if (a_in_valid && a_in_ready) acc++;
            tick();
        end
        a_in_valid = 1'b0;
        check("bp_total_accepts", acc, 5);
        check("bp_drain_count", 32'(a_count), 0);

        // Flush with two beats held
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h40;
        tick();
        a_in_data = 8'h41;
        tick();
        a_in_valid = 1'b0;
        check("flush_pre_count", 32'(a_count), 2);
        a_flush     = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h55;
        a_out_ready = 1'b1;
        #1;
        check("flush_in_ready", a_in_ready, 0);
        check("flush_out_valid", a_out_valid, 0);
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("flush_post_count", 32'(a_count), 0);
        check("flush_post_out_valid", a_out_valid, 0);
        a_in_data  = 8'hAA;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("flush_aa_edge0", a_out_valid, 0);
        tick();
        check("flush_aa_edge1", a_out_valid, 0);
        tick();
        check("flush_aa_edge2_valid", a_out_valid, 1);
        check("flush_aa_edge2_data", a_out_data, 8'hAA);
        tick();

        // Reset while full
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_count == A_CAP) break;
            a_in_data = 8'h60 + 8'(c);
            tick();
        end
        tick();
        check("full_count", 32'(a_count), A_CAP);
        check("full_in_ready", a_in_ready, 0);
`ifdef CLK_PIPELINE_BUFFER_SKID_EN
        a_out_ready = 1'b1;
        #1;
        check("skid_ready_registered", a_in_ready, 0);
        a_out_ready = 1'b0;
        #1;
`endif
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("rst_full_count", 32'(a_count), 0);
        check("rst_full_out_valid", a_out_valid, 0);
        check("rst_full_out_data", a_out_data, 0);
        check("rst_full_in_ready", a_in_ready, 1);

        // Random valid, alternating ready on the 16x4 instance
        for (int c = 0; c < 300; c++) begin
            b_out_ready = c[0];
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = 16'($urandom);
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (b_count == 0) break;
            tick();
        end
        tick();
        check("b_drain_count", 32'(b_count), 0);
        check("b_sb_empty", 32'(b_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_clk_pipeline_buffer
`default_nettype wire
